// File: rtl/arm_step_sequencer_pkg.sv
// arm_pkg: shared types and constants for the arm axis step sequencer
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        PULSE     = 2'd2,
        GAP       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COMPLETE = 2'd0,
        ABORT    = 2'd1,
        LIMIT    = 2'd2,
        FAULT    = 2'd3
    } stop_t;

    localparam int CLK_HZ = 12000000;

endpackage

// File: rtl/arm_step_sequencer_input_synchronizer.sv
// input_synchronizer: flop chain that brings an asynchronous input into the clk_12MHz domain
module input_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_12MHz,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Reset to the input's inactive level so no false event follows reset
    always_ff @(posedge clk_12MHz or negedge resetn) begin
        if (!resetn) sr <= {STAGES{RESET_VAL}};
        else         sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/arm_step_sequencer.sv
// arm_step_sequencer: timed step-pulse engine for one arm axis
module arm_step_sequencer
    import arm_pkg::*;
#(
    parameter int PULSE_CYCLES     = 24,
    parameter int DIR_SETUP_CYCLES = 12,
    parameter int SYNC_STAGES      = 2
) (
    input  logic        clk_12MHz,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] steps,
    input  logic [31:0] div_factor,
    input  logic        dir_cmd,
    input  logic        steppol,
    input  logic        pause,
    input  logic        abort,
    input  logic        limitn,
    input  logic        fault,
    output logic        step_line,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic [31:0] steps_remaining,
    output logic [1:0]  stop_reason
);

    localparam logic [31:0] MIN_PER = 32'(2 * PULSE_CYCLES);

    state_t      state;
    stop_t       why;
    logic        pulse, abort_pend, limitn_s, fault_s, lim, flt, ab, halt, fire;
    logic [31:0] cnt, per, per_cnt;

    input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_limit_sync (
        .clk_12MHz(clk_12MHz), .resetn(resetn), .d(limitn), .q(limitn_s)
    );

    input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_fault_sync (
        .clk_12MHz(clk_12MHz), .resetn(resetn), .d(fault), .q(fault_s)
    );

    assign lim       = ~limitn_s;
    assign flt       = fault_s;
    assign ab        = abort_pend | abort;
    assign halt      = flt | lim | ab;
    assign why       = flt ? FAULT : lim ? LIMIT : ABORT;
    assign fire      = (state == DIR_SETUP && cnt <= 32'd1) || (state == GAP && per_cnt <= 32'd1);
    assign step_line = pulse ^ ~steppol;

    // Move sequencing: command capture, dir setup, pulse width, period gap and stop handling
    always_ff @(posedge clk_12MHz or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            pulse           <= 1'b0;
            abort_pend      <= 1'b0;
            cnt             <= '0;
            per             <= '0;
            per_cnt         <= '0;
            dir             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            steps_remaining <= '0;
            stop_reason     <= COMPLETE;
        end else begin
            done <= 1'b0;
            if (state != IDLE) abort_pend <= ab;
            if (state == IDLE) begin
                if (start && !abort) begin
                    dir             <= dir_cmd;
                    steps_remaining <= steps;
                    per             <= (div_factor > MIN_PER) ? div_factor : MIN_PER;
                    abort_pend      <= 1'b0;
                    if (steps == '0) begin
                        done        <= 1'b1;
                        stop_reason <= COMPLETE;
                    end else begin
                        busy  <= 1'b1;
                        cnt   <= 32'(DIR_SETUP_CYCLES);
                        state <= DIR_SETUP;
                    end
                end
            end else if (fire) begin
                if (halt) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    stop_reason <= why;
                    abort_pend  <= 1'b0;
                end else if (!pause) begin
                    pulse           <= 1'b1;
                    steps_remaining <= (steps_remaining == '0) ? '0 : steps_remaining - 32'd1;
                    cnt             <= 32'(PULSE_CYCLES);
                    per_cnt         <= per;
                    state           <= PULSE;
                end
            end else if (state == PULSE) begin
                if (!pause) per_cnt <= per_cnt - 32'd1;
                if (cnt > 32'd1) begin
                    cnt <= cnt - 32'd1;
                end else begin
                    pulse <= 1'b0;
                    if (steps_remaining == '0) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        stop_reason <= COMPLETE;
                        abort_pend  <= 1'b0;
                    end else begin
                        state <= GAP;
                    end
                end
            end else if (state == DIR_SETUP) begin
                cnt <= cnt - 32'd1;
            end else if (!pause) begin
                per_cnt <= per_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_arm_step_sequencer.sv
// tb_arm_step_sequencer: directed scenario checks for the step sequencer
module tb_arm_step_sequencer;

    logic        clk_12MHz = 1'b0;
    logic        resetn, start, dir_cmd, steppol, pause, abort, limitn, fault;
    logic [31:0] steps, div_factor;
    logic        step_line, dir, busy, done;
    logic [31:0] steps_remaining;
    logic [1:0]  stop_reason;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic        sl[64], bz[64], dn[64], dr[64];
    logic [31:0] rem[64];
    logic [1:0]  srs[64];

    arm_step_sequencer #(.PULSE_CYCLES(2), .DIR_SETUP_CYCLES(3), .SYNC_STAGES(2)) dut (
        .clk_12MHz(clk_12MHz), .resetn(resetn), .start(start), .steps(steps),
        .div_factor(div_factor), .dir_cmd(dir_cmd), .steppol(steppol), .pause(pause),
        .abort(abort), .limitn(limitn), .fault(fault), .step_line(step_line), .dir(dir),
        .busy(busy), .done(done), .steps_remaining(steps_remaining), .stop_reason(stop_reason)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record the outputs of the current cycle, then move to the next cycle
    task automatic tick;
        @(negedge clk_12MHz);
        if (cyc < 64) begin
            sl[cyc] = step_line; bz[cyc] = busy; dn[cyc] = done;
            dr[cyc] = dir; rem[cyc] = steps_remaining; srs[cyc] = stop_reason;
        end
        @(posedge clk_12MHz);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; limitn = 1'b1; fault = 1'b0;
        steppol = 1'b1; steps = '0; div_factor = '0; dir_cmd = 1'b0;
        repeat (2) @(posedge clk_12MHz);
        #1;
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic dc);
        steps = s; div_factor = d; dir_cmd = dc; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; steppol = 1'b1;
        @(negedge clk_12MHz);
        nvec++; if ({step_line, dir, busy, done} !== 4'b0000) begin nerr++; $display("FAIL reset_bits got %b expected 0000", {step_line, dir, busy, done}); end
        nvec++; if (steps_remaining !== 32'd0) begin nerr++; $display("FAIL reset_remaining got %0d expected 0", steps_remaining); end
        nvec++; if (stop_reason !== 2'd0) begin nerr++; $display("FAIL reset_reason got %0d expected 0", stop_reason); end
    endtask

    task automatic test_basic;
        logic [63:0] exp_sl = (64'b11 << 4) | (64'b11 << 14) | (64'b11 << 24);
        do_reset();
        launch(3, 10, 1'b1);
        repeat (29) tick();
        nvec++; if (bz[0] !== 1'b0 || bz[1] !== 1'b1 || dr[1] !== 1'b1) begin nerr++; $display("FAIL basic_start busy0=%b busy1=%b dir1=%b expected 0 1 1", bz[0], bz[1], dr[1]); end
        for (int k = 0; k < 30; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL basic_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (rem[3] !== 32'd3 || rem[4] !== 32'd2 || rem[14] !== 32'd1 || rem[24] !== 32'd0) begin nerr++; $display("FAIL basic_remaining got %0d %0d %0d %0d expected 3 2 1 0", rem[3], rem[4], rem[14], rem[24]); end
        nvec++; if (dn[25] !== 1'b0 || dn[26] !== 1'b1 || dn[27] !== 1'b0) begin nerr++; $display("FAIL basic_done got %b%b%b expected 010", dn[25], dn[26], dn[27]); end
        nvec++; if (bz[25] !== 1'b1 || bz[26] !== 1'b0) begin nerr++; $display("FAIL basic_busy_fall got %b%b expected 10", bz[25], bz[26]); end
        nvec++; if (srs[26] !== 2'd0) begin nerr++; $display("FAIL basic_reason got %0d expected 0", srs[26]); end
    endtask

    task automatic test_zero;
        do_reset();
        launch(0, 10, 1'b1);
        repeat (7) tick();
        nvec++; if (dn[1] !== 1'b1 || dn[2] !== 1'b0) begin nerr++; $display("FAIL zero_done got %b%b expected 10", dn[1], dn[2]); end
        nvec++; if (dr[1] !== 1'b1 || srs[1] !== 2'd0) begin nerr++; $display("FAIL zero_dir_reason got dir=%b reason=%0d expected dir=1 reason=0", dr[1], srs[1]); end
        for (int k = 0; k < 8; k++) begin
            nvec++; if (bz[k] !== 1'b0 || sl[k] !== 1'b0) begin nerr++; $display("FAIL zero_idle cyc %0d busy=%b step=%b expected 0 0", k, bz[k], sl[k]); end
        end
    endtask

    task automatic test_pause;
        logic [63:0] exp_sl = (64'b11 << 4) | (64'b11 << 14) | (64'b11 << 29);
        do_reset();
        launch(3, 10, 1'b0);
        for (int k = 1; k < 35; k++) begin
            pause = (k >= 15 && k <= 19);
            tick();
        end
        pause = 1'b0;
        for (int k = 0; k < 35; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL pause_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (dn[30] !== 1'b0 || dn[31] !== 1'b1) begin nerr++; $display("FAIL pause_done got %b%b expected 01", dn[30], dn[31]); end
    endtask

    task automatic test_clamp;
        logic [63:0] exp_sl = (64'b11 << 4) | (64'b11 << 8) | (64'b11 << 12);
        do_reset();
        launch(3, 1, 1'b1);
        repeat (17) tick();
        for (int k = 0; k < 18; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL clamp_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (dn[14] !== 1'b1 || bz[14] !== 1'b0) begin nerr++; $display("FAIL clamp_done got done=%b busy=%b expected 1 0", dn[14], bz[14]); end
    endtask

    task automatic test_abort;
        logic [63:0] exp_sl = 64'b11 << 4;
        do_reset();
        launch(5, 10, 1'b1);
        for (int k = 1; k < 20; k++) begin
            abort = (k == 5);
            tick();
        end
        abort = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL abort_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (dn[13] !== 1'b0 || dn[14] !== 1'b1 || bz[13] !== 1'b1 || bz[14] !== 1'b0) begin nerr++; $display("FAIL abort_done got done=%b%b busy=%b%b expected 01 10", dn[13], dn[14], bz[13], bz[14]); end
        nvec++; if (srs[14] !== 2'd1 || rem[14] !== 32'd4) begin nerr++; $display("FAIL abort_state got reason=%0d rem=%0d expected 1 4", srs[14], rem[14]); end
    endtask

    task automatic test_start_abort;
        do_reset();
        abort = 1'b1;
        launch(5, 10, 1'b1);
        abort = 1'b0;
        repeat (7) tick();
        for (int k = 0; k < 8; k++) begin
            nvec++; if (bz[k] !== 1'b0 || dn[k] !== 1'b0 || dr[k] !== 1'b0 || rem[k] !== 32'd0) begin nerr++; $display("FAIL start_abort cyc %0d busy=%b done=%b dir=%b rem=%0d expected all 0", k, bz[k], dn[k], dr[k], rem[k]); end
        end
    endtask

    task automatic test_limit;
        do_reset();
        launch(5, 10, 1'b1);
        for (int k = 1; k < 20; k++) begin
            limitn = (k < 10);
            tick();
        end
        limitn = 1'b1;
        nvec++; if (dn[13] !== 1'b0 || dn[14] !== 1'b1) begin nerr++; $display("FAIL limit_done got %b%b expected 01", dn[13], dn[14]); end
        nvec++; if (srs[14] !== 2'd2 || rem[14] !== 32'd4) begin nerr++; $display("FAIL limit_state got reason=%0d rem=%0d expected 2 4", srs[14], rem[14]); end
        nvec++; if (sl[14] !== 1'b0 || bz[14] !== 1'b0) begin nerr++; $display("FAIL limit_no_pulse got step=%b busy=%b expected 0 0", sl[14], bz[14]); end
    endtask

    task automatic test_fault;
        do_reset();
        launch(5, 10, 1'b1);
        for (int k = 1; k < 20; k++) begin
            limitn = (k < 10);
            fault = (k >= 10);
            tick();
        end
        limitn = 1'b1; fault = 1'b0;
        nvec++; if (dn[14] !== 1'b1 || srs[14] !== 2'd3) begin nerr++; $display("FAIL fault_stop got done=%b reason=%0d expected 1 3", dn[14], srs[14]); end
    endtask

    task automatic test_async_reset;
        do_reset();
        launch(3, 10, 1'b1);
        for (int k = 1; k < 10; k++) begin
            if (k == 5) resetn = 1'b0;
            tick();
        end
        nvec++; if (sl[4] !== 1'b1 || bz[4] !== 1'b1) begin nerr++; $display("FAIL areset_before got step=%b busy=%b expected 1 1", sl[4], bz[4]); end
        nvec++; if (sl[5] !== 1'b0 || bz[5] !== 1'b0 || rem[5] !== 32'd0 || dr[5] !== 1'b0) begin nerr++; $display("FAIL areset_clear got step=%b busy=%b rem=%0d dir=%b expected 0 0 0 0", sl[5], bz[5], rem[5], dr[5]); end
        for (int k = 5; k < 10; k++) begin
            nvec++; if (dn[k] !== 1'b0) begin nerr++; $display("FAIL areset_done cyc %0d got %b expected 0", k, dn[k]); end
        end
        resetn = 1'b1;
    endtask

    task automatic test_polarity;
        logic [63:0] exp_sl = ~(64'b11 << 4);
        do_reset();
        steppol = 1'b0;
        launch(1, 10, 1'b0);
        repeat (9) tick();
        for (int k = 0; k < 10; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL polarity_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (dn[6] !== 1'b1) begin nerr++; $display("FAIL polarity_done got %b expected 1", dn[6]); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_sl = (64'b11 << 4) | (64'b11 << 14) | (64'b11 << 20);
        do_reset();
        launch(2, 10, 1'b1);
        for (int k = 1; k < 25; k++) begin
            start = (k == 6 || k == 16);
            steps = (k == 6) ? 32'd9 : 32'd1;
            dir_cmd = 1'b0;
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            nvec++; if (sl[k] !== exp_sl[k]) begin nerr++; $display("FAIL b2b_step cyc %0d got %b expected %b", k, sl[k], exp_sl[k]); end
        end
        nvec++; if (dr[7] !== 1'b1 || rem[7] !== 32'd1 || rem[14] !== 32'd0) begin nerr++; $display("FAIL b2b_ignored got dir=%b rem7=%0d rem14=%0d expected 1 1 0", dr[7], rem[7], rem[14]); end
        nvec++; if (dn[16] !== 1'b1 || dr[17] !== 1'b0 || rem[17] !== 32'd1 || bz[17] !== 1'b1) begin nerr++; $display("FAIL b2b_second got done16=%b dir17=%b rem17=%0d busy17=%b expected 1 0 1 1", dn[16], dr[17], rem[17], bz[17]); end
        nvec++; if (dn[22] !== 1'b1 || srs[22] !== 2'd0) begin nerr++; $display("FAIL b2b_done got done=%b reason=%0d expected 1 0", dn[22], srs[22]); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0; limitn = 1'b1; fault = 1'b0;
        steppol = 1'b1; steps = '0; div_factor = '0; dir_cmd = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_pause();
        test_clamp();
        test_abort();
        test_start_abort();
        test_limit();
        test_fault();
        test_async_reset();
        test_polarity();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
